// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out serializer.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/piso_gap_timer.sv
// Loadable down-counter that times the idle gap between frames.
module piso_gap_timer
  import piso_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 en,
  input  logic [GAP_CNT_W-1:0] load_val,
  output logic                 done
);

  logic [GAP_CNT_W-1:0] cnt_q;
  logic [GAP_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - GAP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Done while on the final gap cycle, so the FSM leaves after exactly load_val cycles.
  assign done = (cnt_q <= GAP_CNT_W'(1));

endmodule

// File: rtl/piso_serializer.sv
// Serializes DATA_W-bit words onto a single line, one bit per clock, with optional gaps.
// Define PISO_PARITY_EN to append an even-parity bit after the last data bit of each frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   DATA_W     = 8,
  parameter int   MSB_FIRST  = 1,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_LVL   = 1'b0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              out_bit,
  output logic              out_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(FRAME_LEN - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYCLES);
  localparam bit                   GAP_EN   = (GAP_CYCLES > 0);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              out_bit_q, out_bit_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              accept;
  logic              gap_load;
  logic              gap_en;
  logic              gap_done;
`ifdef PISO_PARITY_EN
  logic              par_q, par_d;
`endif

  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  // Ready depends on state only: idle, or the final beat of a frame when no gap follows.
  always_comb begin
    s_ready = (state_q == IDLE) ||
              ((state_q == SHIFT) && (bit_cnt_q == '0) && !GAP_EN);
  end

  assign accept = s_valid && s_ready;

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    out_bit_d    = IDLE_LVL;
    out_valid_d  = 1'b0;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;
    gap_load     = 1'b0;
    gap_en       = 1'b0;
`ifdef PISO_PARITY_EN
    par_d        = par_q;
`endif

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end

      SHIFT: begin
        if (bit_cnt_q != '0) begin
          bit_cnt_d    = bit_cnt_q - CNT_W'(1);
          out_valid_d  = 1'b1;
          busy_d       = 1'b1;
          out_bit_d    = head_bit(sr_q);
          sr_d         = shift_out(sr_q);
          frame_done_d = (bit_cnt_q == CNT_W'(1));
`ifdef PISO_PARITY_EN
          if (bit_cnt_q == CNT_W'(1)) begin
            out_bit_d = par_q;
          end
`endif
        end else if (GAP_EN) begin
          state_d  = GAP;
          gap_load = 1'b1;
          busy_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      GAP: begin
        gap_en = 1'b1;
        if (gap_done) begin
          state_d = IDLE;
        end else begin
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Accepting a word (from idle or on a zero-bubble last beat) presents its first bit next cycle.
    if (accept) begin
      state_d      = SHIFT;
      bit_cnt_d    = CNT_LOAD;
      out_valid_d  = 1'b1;
      busy_d       = 1'b1;
      frame_done_d = 1'b0;
      out_bit_d    = head_bit(s_data);
      sr_d         = shift_out(s_data);
`ifdef PISO_PARITY_EN
      par_d        = ^s_data;
`endif
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      out_bit_q    <= IDLE_LVL;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      out_bit_q    <= out_bit_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef PISO_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  piso_gap_timer u_gap_timer (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .load     (gap_load),
    .en       (gap_en),
    .load_val (GAP_LOAD),
    .done     (gap_done)
  );

  assign out_bit    = out_bit_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three configurations checked cycle by cycle against a timeline model.
module tb_piso_serializer;

  localparam int   MSB0 = 1, GAP0 = 0;
  localparam logic IDL0 = 1'b0;
  localparam int   MSB1 = 0, GAP1 = 0;
  localparam logic IDL1 = 1'b0;
  localparam int   MSB2 = 1, GAP2 = 3;
  localparam logic IDL2 = 1'b1;
`ifdef PISO_PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [2:0] s_valid_v;
  logic [2:0] s_ready_v;
  logic [7:0] s_data_v [3];
  logic [2:0] out_bit_v;
  logic [2:0] out_valid_v;
  logic [2:0] busy_v;
  logic [2:0] frame_done_v;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] wq [0:7];
  int         acc [0:7];
  int         total;
  logic [4:0] exp_v [0:127];
  logic [4:0] obs_v [0:127];

  always #5 sys_clk = ~sys_clk;

  piso_serializer #(.DATA_W(8), .MSB_FIRST(MSB0), .GAP_CYCLES(GAP0), .IDLE_LVL(IDL0)) dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .s_valid(s_valid_v[0]), .s_ready(s_ready_v[0]),
    .s_data(s_data_v[0]), .out_bit(out_bit_v[0]), .out_valid(out_valid_v[0]),
    .busy(busy_v[0]), .frame_done(frame_done_v[0]));

  piso_serializer #(.DATA_W(8), .MSB_FIRST(MSB1), .GAP_CYCLES(GAP1), .IDLE_LVL(IDL1)) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .s_valid(s_valid_v[1]), .s_ready(s_ready_v[1]),
    .s_data(s_data_v[1]), .out_bit(out_bit_v[1]), .out_valid(out_valid_v[1]),
    .busy(busy_v[1]), .frame_done(frame_done_v[1]));

  piso_serializer #(.DATA_W(8), .MSB_FIRST(MSB2), .GAP_CYCLES(GAP2), .IDLE_LVL(IDL2)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .s_valid(s_valid_v[2]), .s_ready(s_ready_v[2]),
    .s_data(s_data_v[2]), .out_bit(out_bit_v[2]), .out_valid(out_valid_v[2]),
    .busy(busy_v[2]), .frame_done(frame_done_v[2]));

  function automatic int msb_of(input int idx);
    return (idx == 0) ? MSB0 : (idx == 1) ? MSB1 : MSB2;
  endfunction

  function automatic int gap_of(input int idx);
    return (idx == 0) ? GAP0 : (idx == 1) ? GAP1 : GAP2;
  endfunction

  function automatic logic idle_of(input int idx);
    return (idx == 0) ? IDL0 : (idx == 1) ? IDL1 : IDL2;
  endfunction

  function automatic logic [4:0] sample(input int idx);
    return {s_ready_v[idx], out_valid_v[idx], out_bit_v[idx], busy_v[idx], frame_done_v[idx]};
  endfunction

  // Expected per-cycle tuple {s_ready, out_valid, out_bit, busy, frame_done}.
  // Cycle n is the interval just before rising edge n; word i is accepted on edge acc[i].
  task automatic build_expect(input int idx, input int nwords);
    int   g;
    int   n;
    logic w_bit;
    g = gap_of(idx);
    acc[0] = 0;
    for (int i = 1; i < nwords; i++)
      acc[i] = acc[i-1] + FLEN + ((g > 0) ? g + 1 : 0);
    total = acc[nwords-1] + FLEN + g + 3;
    for (int c = 0; c < total; c++)
      exp_v[c] = {1'b1, 1'b0, idle_of(idx), 1'b0, 1'b0};
    for (int i = 0; i < nwords; i++) begin
      for (int k = 0; k < FLEN; k++) begin
        n = acc[i] + 1 + k;
        if (k >= 8)               w_bit = ^wq[i];
        else if (msb_of(idx) != 0) w_bit = wq[i][7-k];
        else                      w_bit = wq[i][k];
        exp_v[n] = {(k == FLEN-1) && (g == 0), 1'b1, w_bit, 1'b1, k == FLEN-1};
      end
      for (int j = 1; j <= g; j++)
        exp_v[acc[i] + FLEN + j] = {1'b0, 1'b0, idle_of(idx), 1'b1, 1'b0};
    end
  endtask

  // Upstream holds each word valid until the model's accept edge, then moves on.
  task automatic run_stream(input int idx, input int nwords);
    int cur;
    build_expect(idx, nwords);
    cur = 0;
    for (int n = 0; n < total; n++) begin
      @(negedge sys_clk);
      s_valid_v[idx] = (cur < nwords);
      s_data_v[idx]  = (cur < nwords) ? wq[cur] : 8'($urandom_range(0, 255));
      obs_v[n] = sample(idx);
      if ((cur < nwords) && (n == acc[cur])) cur++;
    end
    s_valid_v[idx] = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] want;
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    for (int i = 0; i < 3; i++) begin
      want = {1'b1, 1'b0, idle_of(i), 1'b0, 1'b0};
      vectors++;
      if (sample(i) !== want) begin
        miscompares++;
        $display("[TB] FAIL reset_hold dut%0d: got %b expected %b", i, sample(i), want);
      end
    end
    sys_rst = 1'b0;
    @(negedge sys_clk);
    for (int i = 0; i < 3; i++) begin
      want = {1'b1, 1'b0, idle_of(i), 1'b0, 1'b0};
      vectors++;
      if (sample(i) !== want) begin
        miscompares++;
        $display("[TB] FAIL reset_release dut%0d: got %b expected %b", i, sample(i), want);
      end
    end
  endtask

  task automatic test_msb_first();
    wq[0] = 8'hA5;
    run_stream(0, 1);
    for (int n = 0; n < total; n++) begin
      vectors++;
      if (obs_v[n] !== exp_v[n]) begin
        miscompares++;
        $display("[TB] FAIL msb_a5 cycle %0d: got %b expected %b", n, obs_v[n], exp_v[n]);
      end
    end
  endtask

  task automatic test_lsb_first();
    wq[0] = 8'hA5;
    wq[1] = 8'h01;
    for (int t = 0; t < 2; t++) begin
      wq[0] = (t == 0) ? 8'hA5 : 8'h01;
      run_stream(1, 1);
      for (int n = 0; n < total; n++) begin
        vectors++;
        if (obs_v[n] !== exp_v[n]) begin
          miscompares++;
          $display("[TB] FAIL lsb_word%0d cycle %0d: got %b expected %b", t, n, obs_v[n], exp_v[n]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    wq[0] = 8'hFF;
    wq[1] = 8'h00;
    run_stream(0, 2);
    for (int n = 0; n < total; n++) begin
      vectors++;
      if (obs_v[n] !== exp_v[n]) begin
        miscompares++;
        $display("[TB] FAIL b2b cycle %0d: got %b expected %b", n, obs_v[n], exp_v[n]);
      end
    end
  endtask

  task automatic test_gap();
    wq[0] = 8'h5A;
    wq[1] = 8'hC3;
    run_stream(2, 2);
    for (int n = 0; n < total; n++) begin
      vectors++;
      if (obs_v[n] !== exp_v[n]) begin
        miscompares++;
        $display("[TB] FAIL gap cycle %0d: got %b expected %b", n, obs_v[n], exp_v[n]);
      end
    end
  endtask

  task automatic test_parity_words();
    wq[0] = 8'hA5;
    wq[1] = 8'h07;
    run_stream(0, 2);
    for (int n = 0; n < total; n++) begin
      vectors++;
      if (obs_v[n] !== exp_v[n]) begin
        miscompares++;
        $display("[TB] FAIL parity_words cycle %0d: got %b expected %b", n, obs_v[n], exp_v[n]);
      end
    end
  endtask

  // Reset lands on the edge that ends the 4th bit of 8'hC3 (MSB first: 1,1,0,0).
  task automatic test_reset_mid_frame();
    logic [7:0] w;
    logic [4:0] want;
    w = 8'hC3;
    @(negedge sys_clk);
    s_valid_v[0] = 1'b1;
    s_data_v[0]  = w;
    for (int k = 0; k < 4; k++) begin
      @(negedge sys_clk);
      s_valid_v[0] = 1'b0;
      want = {1'b0, 1'b1, w[7-k], 1'b1, 1'b0};
      vectors++;
      if (sample(0) !== want) begin
        miscompares++;
        $display("[TB] FAIL midrst_bit%0d: got %b expected %b", k, sample(0), want);
      end
    end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      want = {1'b1, 1'b0, IDL0, 1'b0, 1'b0};
      vectors++;
      if (sample(0) !== want) begin
        miscompares++;
        $display("[TB] FAIL midrst_after%0d: got %b expected %b", c, sample(0), want);
      end
      @(negedge sys_clk);
    end
    wq[0] = 8'h81;
    run_stream(0, 1);
    for (int n = 0; n < total; n++) begin
      vectors++;
      if (obs_v[n] !== exp_v[n]) begin
        miscompares++;
        $display("[TB] FAIL midrst_fresh81 cycle %0d: got %b expected %b", n, obs_v[n], exp_v[n]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int idx = 0; idx < 3; idx++) begin
        for (int i = 0; i < 3; i++) wq[i] = 8'($urandom_range(0, 255));
        run_stream(idx, 3);
        for (int n = 0; n < total; n++) begin
          vectors++;
          if (obs_v[n] !== exp_v[n]) begin
            miscompares++;
            $display("[TB] FAIL random r%0d dut%0d cycle %0d: got %b expected %b",
                     r, idx, n, obs_v[n], exp_v[n]);
          end
        end
      end
    end
  endtask

  initial begin
    sys_rst   = 1'b1;
    s_valid_v = '0;
    for (int i = 0; i < 3; i++) s_data_v[i] = 8'h00;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_gap();
    test_parity_words();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
